// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: walks fetch_pc through a combinational instruction
// memory, buffers {pc, word} pairs in a small FIFO for decode, halts on ebreak.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        halted,
  output logic [1:0]  state_dbg
);

  // Handshake: an entry leaves the queue on a rising edge where instr_valid && instr_ready,
  // unless redirect_valid or reset is high that cycle (the queue is discarded instead).

  localparam int PW = (DEPTH == 4) ? 2 : 1;
  localparam int CW = PW + 1;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     fetch_pc_q;
  logic [31:0]     pc_mem   [DEPTH];
  logic [31:0]     word_mem [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            full, hs, push, pop;

  assign imem_addr   = fetch_pc_q;
  assign instr_valid = (count_q != '0);
  assign instr       = word_mem[rd_ptr_q];
  assign instr_pc    = pc_mem[rd_ptr_q];
  assign full        = (count_q == CW'(DEPTH));
  assign hs          = instr_valid && instr_ready;
  assign pop         = hs && !redirect_valid;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH:  if (push && imem_rdata == EBREAK) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
    if (redirect_valid) state_d = ST_FETCH;
  end

  // A full queue still accepts a push when the head leaves in the same cycle.
  always_comb begin
    push      = (state_q == ST_FETCH) && !redirect_valid && (!full || hs);
    halted    = (state_q == ST_HALTED);
    state_dbg = state_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else if (redirect_valid) begin
      fetch_pc_q <= {redirect_pc[31:2], 2'b00};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      if (push) begin
        fetch_pc_q <= fetch_pc_q + 32'd4;
        wr_ptr_q   <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      pc_mem[wr_ptr_q]   <= fetch_pc_q;
      word_mem[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: driver pushes expected {pc, word} pairs,
// a negedge monitor pops and compares each accepted instruction.
module tb_imem_fetch_ctrl;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic        halted;
  logic [1:0]  state_dbg;
  logic        ebreak_mode;

  logic [63:0] exp_q[$];
  int          tests = 0;
  int          fails = 0;

  imem_fetch_ctrl #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .halted(halted), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // instruction memory model
  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic eb);
    case (a)
      32'h0000_0000: return 32'h0240_0413;
      32'h0000_0004: return 32'h0040_0493;
      32'h0000_0008: return 32'h0094_0333;
      32'h0000_000C: return eb ? 32'h0010_0073 : 32'h00C0_0513;
      32'h0000_003C: return 32'h0129_A0A3;
      32'hFFFF_FFFC: return 32'hDEAD_BEEF;
      default:       return 32'h1300_0000 | {8'h00, a[23:0]};
    endcase
  endfunction

  always_comb imem_rdata = mem_word(imem_addr, ebreak_mode);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_instr(input logic [31:0] pc, input logic [31:0] word);
    exp_q.push_back({pc, word});
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset && !redirect_valid && instr_valid && instr_ready && exp_q.size() > 0)
      check("stream", {instr_pc, instr}, exp_q.pop_front());
  end

  initial begin
    reset = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    ebreak_mode = 1'b0;

    // reset state and first-fetch latency
    step(2);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'h0);
    check("rst_state", 64'(state_dbg), 64'd0);
    reset = 1'b0;
    expect_instr(32'h0, 32'h0240_0413);
    expect_instr(32'h4, 32'h0040_0493);
    expect_instr(32'h8, 32'h0094_0333);
    step(1);
    check("lat_valid_c1", 64'(instr_valid), 64'd0);
    check("lat_state_c1", 64'(state_dbg), 64'd1);
    step(1);
    check("lat_pc_c2", {31'd0, instr_valid, instr_pc}, {32'd1, 32'h0});
    step(1);
    check("seq_pc_c3", {31'd0, instr_valid, instr_pc}, {32'd1, 32'h4});
    step(1);
    check("seq_pc_c4", {31'd0, instr_valid, instr_pc}, {32'd1, 32'h8});
    step(1);
    check("drain_a", 64'(exp_q.size()), 64'd0);

    // back-pressure: queue saturates, then drains without loss
    reset = 1'b1;
    step(1);
    reset = 1'b0; instr_ready = 1'b0;
    expect_instr(32'h00, 32'h0240_0413);
    expect_instr(32'h04, 32'h0040_0493);
    expect_instr(32'h08, 32'h0094_0333);
    expect_instr(32'h0C, 32'h00C0_0513);
    expect_instr(32'h10, 32'h1300_0010);
    step(5);
    check("full_addr", 64'(imem_addr), 64'(4 * DEPTH));
    check("full_head", {instr_pc, instr}, {32'h0, 32'h0240_0413});
    check("full_valid", 64'(instr_valid), 64'd1);
    instr_ready = 1'b1;
    step(6);
    check("drain_b", 64'(exp_q.size()), 64'd0);

    // mid-stream redirect drops queued entries
    redirect_valid = 1'b1; redirect_pc = 32'd60;
    expect_instr(32'd60, 32'h0129_A0A3);
    expect_instr(32'd64, 32'h1300_0040);
    expect_instr(32'd68, 32'h1300_0044);
    step(1);
    check("redir_flush", 64'(instr_valid), 64'd0);
    check("redir_addr", 64'(imem_addr), 64'd60);
    redirect_valid = 1'b0;
    step(1);
    check("redir_first", {instr_valid, instr_pc, instr}, {1'b1, 32'd60, 32'h0129_A0A3});
    step(3);
    check("drain_c", 64'(exp_q.size()), 64'd0);

    // ebreak at address 12 halts fetch
    ebreak_mode = 1'b1; reset = 1'b1;
    step(1);
    reset = 1'b0;
    expect_instr(32'h00, 32'h0240_0413);
    expect_instr(32'h04, 32'h0040_0493);
    expect_instr(32'h08, 32'h0094_0333);
    expect_instr(32'h0C, 32'h0010_0073);
    step(4);
    check("pre_halt", 64'(halted), 64'd0);
    step(1);
    check("halt_flag", {halted, instr_valid}, {1'b1, 1'b1});
    check("halt_addr", 64'(imem_addr), 64'd16);
    check("halt_state", 64'(state_dbg), 64'd2);
    step(1);
    check("halt_empty", 64'(instr_valid), 64'd0);
    step(2);
    check("halt_hold", {halted, instr_valid, imem_addr}, {1'b1, 1'b0, 32'd16});
    check("drain_d", 64'(exp_q.size()), 64'd0);
    ebreak_mode = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0;
    expect_instr(32'h0, 32'h0240_0413);
    expect_instr(32'h4, 32'h0040_0493);
    step(1);
    check("unhalt", 64'(halted), 64'd0);
    redirect_valid = 1'b0;
    step(1);
    check("resume", {instr_pc, instr}, {32'h0, 32'h0240_0413});
    step(2);
    check("drain_d2", 64'(exp_q.size()), 64'd0);

    // address wrap and misaligned redirect target
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    expect_instr(32'hFFFF_FFFC, 32'hDEAD_BEEF);
    expect_instr(32'h0, 32'h0240_0413);
    step(1);
    check("wrap_addr", 64'(imem_addr), 64'hFFFF_FFFC);
    redirect_valid = 1'b0;
    step(1);
    check("wrap_pc0", 64'(instr_pc), 64'hFFFF_FFFC);
    step(1);
    check("wrap_pc1", 64'(instr_pc), 64'h0);
    step(1);
    check("drain_e", 64'(exp_q.size()), 64'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h6;
    expect_instr(32'h4, 32'h0040_0493);
    expect_instr(32'h8, 32'h0094_0333);
    step(1);
    check("align_addr", 64'(imem_addr), 64'h4);
    redirect_valid = 1'b0;
    step(3);
    check("drain_e2", 64'(exp_q.size()), 64'd0);

    // reset beats redirect with a full queue
    instr_ready = 1'b0;
    step(DEPTH + 2);
    check("pre_rst_full", 64'(instr_valid), 64'd1);
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd60;
    step(1);
    check("rst_over_valid", 64'(instr_valid), 64'd0);
    check("rst_over_addr", 64'(imem_addr), 64'h0);
    check("rst_over_halted", 64'(halted), 64'd0);
    check("rst_over_state", 64'(state_dbg), 64'd0);
    reset = 1'b0; redirect_valid = 1'b0;
    step(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, byte address of the first fetch after reset.
REQ-002 SHALL have parameter DEPTH, default 2, instruction-queue entries; legal values 2 or 4.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port imem_addr  output  32  byte address to the combinational instruction memory.
REQ-006 SHALL have port imem_rdata  input  32  instruction word at imem_addr, valid in the same cycle.
REQ-007 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-008 SHALL have port redirect_pc  input  32  redirect target.
REQ-009 SHALL have port instr_valid  output  1  queue head holds a valid instruction.
REQ-010 SHALL have port instr_ready  input  1  decode accepts the head this cycle.
REQ-011 SHALL have port instr  output  32  instruction word at queue head.
REQ-012 SHALL have port instr_pc  output  32  byte address of instr.
REQ-013 SHALL have port halted  output  1  high while in state HALTED.

Function
REQ-014 SHALL hold a registered fetch_pc and drive imem_addr = fetch_pc combinationally.
REQ-015 SHALL implement states IDLE, FETCH, HALTED.
REQ-016 IDLE: no push; unconditional transition to FETCH next cycle.
REQ-017 FETCH: push {fetch_pc, imem_rdata} and advance fetch_pc by 4 when count < DEPTH, or count == DEPTH with a pop this cycle.
REQ-018 Pop SHALL occur when instr_valid && instr_ready; instr_valid = (count != 0); instr/instr_pc = head entry, don't-care when count == 0.
REQ-019 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-020 Full queue with no pop: no push, fetch_pc held, imem_addr stable.
REQ-021 fetch_pc SHALL wrap modulo 2^32 (32'hFFFFFFFC + 4 = 0).
REQ-022 When the pushed word equals 32'h00100073 (ebreak): push it, advance fetch_pc, enter HALTED.
REQ-023 HALTED: no further pushes; pops continue until empty; halted = 1.
REQ-024 redirect_valid SHALL take priority over all other events in any state: queue flushed (count <= 0), no push, pop ignored, fetch_pc <= {redirect_pc[31:2], 2'b00}, state <= FETCH.
REQ-025 redirect_valid in IDLE SHALL take effect identically (state -> FETCH).
REQ-026 First instruction after redirect SHALL appear on instr with instr_valid = 1 exactly 1 cycle after the redirect cycle.
REQ-027 First instruction after reset deassertion SHALL appear 2 cycles after (IDLE, then FETCH push).

Reset
REQ-028 reset high at a clock edge: state <= IDLE, fetch_pc <= RESET_PC, count <= 0, queue pointers <= 0.
REQ-029 During and after reset: instr_valid = 0, halted = 0, imem_addr = RESET_PC.
REQ-030 reset SHALL override redirect_valid and any push/pop in the same cycle, including mid-stream and in HALTED.

Verification
REQ-031 Reset, then instr_ready = 1, imem holds 0:02400413, 4:00400493, 8:00940333 -> instr/instr_pc sequence 02400413/0, 00400493/4, 00940333/8 on consecutive cycles, first 2 cycles after reset release.
REQ-032 instr_ready = 0 for 5 cycles after reset -> count saturates at DEPTH, imem_addr holds 4*DEPTH, head stays 02400413/0; ready = 1 -> no instruction lost or duplicated.
REQ-033 Mid-stream redirect_valid = 1, redirect_pc = 60 (ready = 1) -> next cycle instr = 0129A0A3, instr_pc = 60; queued older entries never presented.
REQ-034 Word 00100073 at address 12 -> pushed, halted = 1 next cycle, imem_addr stays 16, instr_valid falls after queue drains; redirect to 0 -> halted = 0, fetch resumes at 02400413.
REQ-035 redirect_pc = 32'hFFFFFFFC -> instr_pc = FFFFFFFC then 00000000; redirect_pc = 32'h00000006 -> imem_addr = 4.
REQ-036 reset asserted with a full queue and redirect_valid = 1 -> after the edge instr_valid = 0, imem_addr = RESET_PC, halted = 0.
